fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. Holds the PC, selects the next PC (sequential, branch, jump, register jump), and drives the instruction-memory address. Latches the fetched word and PC+4 into the IF/ID register for the decode stage, whose immediate field `[15:0]` feeds the 16→32 sign extender. Handles hazard stalls, control-hazard flushes and HALT detection.

---
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// This module is the instruction-fetch stage and the IF/ID pipeline register of
// the MIPS pipeline. It holds the PC, selects the next PC, drives the
// instruction-memory address, and latches the fetched word and PC+4 into the
// IF/ID register. It also handles load-use stalls, control-hazard flushes and
// HALT detection.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : a fetched word whose opcode equals HALT_OP moves fetch into a
//               HALT state. In that state the PC is frozen and NOPs are issued
//               until an enabled flush redirects fetch.
//   undefined : there is no halt behaviour. o_halt is tied to 0 and HALT_OP is
//               fetched like any other instruction.
//
// Parameters
//   NBITS    instruction and PC width
//   HALT_OP  opcode in bits [NBITS-1:NBITS-6] that marks HALT
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_rst_n        synchronous, active-low reset (overrides i_enable)
//   i_enable       global run enable; 0 freezes PC, IF/ID and state
//   i_stall        load-use stall from the hazard unit
//   i_flush        control-hazard flush; wins over i_stall
//   i_pc_src       next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register
//   i_branch_addr  branch target
//   i_jump_addr    jump target
//   i_reg_addr     register-jump target
//   i_imem_data    instruction word at o_imem_addr (combinational read)
//   o_imem_addr    current PC
//   o_instr        IF/ID instruction
//   o_pc_plus4     IF/ID PC+4
//   o_valid        IF/ID holds a real instruction
//   o_halt         fetch is halted on a HALT word
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          NBITS   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [1:0]       i_pc_src,
    input  logic [NBITS-1:0] i_branch_addr,
    input  logic [NBITS-1:0] i_jump_addr,
    input  logic [NBITS-1:0] i_reg_addr,
    input  logic [NBITS-1:0] i_imem_data,
    output logic [NBITS-1:0] o_imem_addr,
    output logic [NBITS-1:0] o_instr,
    output logic [NBITS-1:0] o_pc_plus4,
    output logic             o_valid,
    output logic             o_halt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // PC select encodings
    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_REG    = 2'b11;

    state_t           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic [NBITS-1:0] pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;

    logic [NBITS-1:0] pc_plus4;
    logic [NBITS-1:0] next_pc;
    logic             halt_hit;

    // The sum wraps naturally modulo 2^NBITS, so PC 0x...FC steps to 0.
    assign pc_plus4 = pc_q + NBITS'(4);

    always_comb begin
        next_pc = pc_plus4;
        unique case (i_pc_src)
            SRC_SEQ:    next_pc = pc_plus4;
            SRC_BRANCH: next_pc = i_branch_addr;
            SRC_JUMP:   next_pc = i_jump_addr;
            SRC_REG:    next_pc = i_reg_addr;
            default:    next_pc = pc_plus4;
        endcase
    end

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = (i_imem_data[NBITS-1:NBITS-6] == HALT_OP);
`else
    // Without halt detection, the HALT opcode is just another instruction.
    assign halt_hit = 1'b0;
`endif

    // Next-state and IF/ID logic. Everything holds by default. That default is
    // what gives the i_enable=0 freeze and the plain-stall hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;

        if (i_enable) begin
            unique case (state_q)
                ST_RUN: begin
                    if (i_flush) begin
                        // The redirect slot becomes a bubble. The target word
                        // arrives on the following edge.
                        pc_d       = next_pc;
                        instr_d    = '0;
                        pc_plus4_d = '0;
                        valid_d    = 1'b0;
                    end else if (!i_stall) begin
                        instr_d    = i_imem_data;
                        pc_plus4_d = pc_plus4;
                        valid_d    = 1'b1;
                        if (halt_hit) begin
                            // The HALT word goes downstream as a valid
                            // instruction. The PC stays parked on its address.
                            state_d = ST_HALT;
                        end else begin
                            pc_d = next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    instr_d    = '0;
                    pc_plus4_d = '0;
                    valid_d    = 1'b0;
                    // Only a flush gets us out. In that case the HALT came
                    // from a mispredicted path.
                    if (i_flush) begin
                        pc_d    = next_pc;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign o_imem_addr = pc_q;
    assign o_instr     = instr_q;
    assign o_pc_plus4  = pc_plus4_q;
    assign o_valid     = valid_q;

`ifdef FETCH_HALT_DETECT_EN
    assign o_halt = (state_q == ST_HALT);
`else
    assign o_halt = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [1:0]  i_pc_src = 2'b00;
    logic [31:0] i_branch_addr = '0;
    logic [31:0] i_jump_addr = '0;
    logic [31:0] i_reg_addr = '0;
    logic [31:0] i_imem_data;
    logic [31:0] o_imem_addr;
    logic [31:0] o_instr;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halt;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_pc_src      (i_pc_src),
        .i_branch_addr (i_branch_addr),
        .i_jump_addr   (i_jump_addr),
        .i_reg_addr    (i_reg_addr),
        .i_imem_data   (i_imem_data),
        .o_imem_addr   (o_imem_addr),
        .o_instr       (o_instr),
        .o_pc_plus4    (o_pc_plus4),
        .o_valid       (o_valid),
        .o_halt        (o_halt)
    );

    // Instruction memory contents: a few fixed words from the test plan,
    // occasional HALT words, and a hash (never HALT) elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] w;
        if (addr == 32'h0)        return 32'h20010005;
        if (addr == 32'h4)        return 32'h20020007;
        if (addr == 32'h10)       return 32'hFC000000;
        if (addr[8:2] == 7'h55)   return {6'h3F, addr[25:0]};
        w = (addr * 32'h9E3779B1) ^ 32'h5A5A1234;
        w[31] = 1'b0;
        return w;
    endfunction

    assign i_imem_data = mem_word(o_imem_addr);

    // Reference model state
    logic [31:0] m_pc = '0, m_instr = '0, m_pp4 = '0;
    bit          m_valid = 1'b0, m_halt = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the reference model. It uses the inputs about to be applied.
    task automatic model_update(input bit rst_n, en, stall, flush, input logic [1:0] src,
                                input logic [31:0] b, j, r);
        logic [31:0] word, target;
        word = mem_word(m_pc);
        case (src)
            2'd0: target = m_pc + 32'd4;
            2'd1: target = b;
            2'd2: target = j;
            default: target = r;
        endcase
        if (!rst_n) begin
            m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halt = 0;
        end else if (en) begin
            if (m_halt) begin
                m_instr = 0; m_pp4 = 0; m_valid = 0;
                if (flush) begin m_pc = target; m_halt = 0; end
            end else if (flush) begin
                m_pc = target; m_instr = 0; m_pp4 = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = word; m_pp4 = m_pc + 32'd4; m_valid = 1;
                if (HALT_EN && word[31:26] == 6'b111111) m_halt = 1;
                else m_pc = target;
            end
        end
    endtask

    task automatic step(input bit rst_n, en, stall, flush, input logic [1:0] src,
                        input logic [31:0] b, j, r);
        i_rst_n = rst_n; i_enable = en; i_stall = stall; i_flush = flush;
        i_pc_src = src; i_branch_addr = b; i_jump_addr = j; i_reg_addr = r;
        model_update(rst_n, en, stall, flush, src, b, j, r);
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d rst_n=%b en=%b st=%b fl=%b src=%0d pc=%h instr=%h pp4=%h v=%b h=%b",
                 n_txn, rst_n, en, stall, flush, src, o_imem_addr, o_instr, o_pc_plus4, o_valid, o_halt);
        check_eq("pc",     o_imem_addr, m_pc);
        check_eq("instr",  o_instr,     m_instr);
        check_eq("pc4",    o_pc_plus4,  m_pp4);
        check_eq("valid",  {31'd0, o_valid}, {31'd0, m_valid});
        check_eq("halt",   {31'd0, o_halt},  {31'd0, m_halt});
    endtask

    task automatic run_seq();
        step(1, 1, 0, 0, 2'd0, 0, 0, 0);
    endtask

    initial begin
        // Reset, then sequential fetch
        step(0, 1, 0, 0, 2'd0, 0, 0, 0);
        step(0, 1, 0, 0, 2'd0, 0, 0, 0);
        check_eq("rst_pc", o_imem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        run_seq();
        check_eq("seq0_instr", o_instr, 32'h20010005);
        check_eq("seq0_pc4", o_pc_plus4, 32'h4);
        run_seq();
        check_eq("seq1_instr", o_instr, 32'h20020007);
        check_eq("seq1_pc4", o_pc_plus4, 32'h8);

        // Stall at PC=8
        step(1, 1, 1, 0, 2'd0, 0, 0, 0);
        step(1, 1, 1, 0, 2'd0, 0, 0, 0);
        check_eq("stall_pc", o_imem_addr, 32'h8);
        check_eq("stall_hold", o_instr, 32'h20020007);
        run_seq();
        check_eq("stall_rel_pc4", o_pc_plus4, 32'hC);

        // Branch redirect with stall+flush together
        step(1, 1, 1, 1, 2'd1, 32'h40, 0, 0);
        check_eq("br_pc", o_imem_addr, 32'h40);
        check_eq("br_nop", o_instr, 32'h0);
        run_seq();
        check_eq("br_tgt_instr", o_instr, mem_word(32'h40));
        check_eq("br_tgt_pc4", o_pc_plus4, 32'h44);

        // HALT at 0x10
        step(1, 1, 0, 1, 2'd2, 0, 32'h10, 0);
        run_seq();
        check_eq("halt_instr", o_instr, 32'hFC000000);
        check_eq("halt_flag", {31'd0, o_halt}, {31'd0, HALT_EN});
        check_eq("halt_pc", o_imem_addr, HALT_EN ? 32'h10 : 32'h14);
        run_seq();
        run_seq();

        // Flush out of HALT
        step(1, 1, 0, 1, 2'd2, 0, 32'h80, 0);
        check_eq("unhalt_pc", o_imem_addr, 32'h80);
        check_eq("unhalt_flag", {31'd0, o_halt}, 32'd0);
        run_seq();

        // Enable low for 3 cycles with noisy inputs
        for (int k = 0; k < 3; k++)
            step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 $urandom & ~32'd3, $urandom & ~32'd3, $urandom & ~32'd3);
        check_eq("en_freeze_pc", o_imem_addr, 32'h84);

        // Wrap at 0xFFFFFFFC
        step(1, 1, 0, 1, 2'd3, 0, 0, 32'hFFFFFFFC);
        run_seq();
        check_eq("wrap_pc", o_imem_addr, 32'h0);
        check_eq("wrap_pc4", o_pc_plus4, 32'h0);

        // Reset asserted mid-stall
        run_seq();
        step(0, 1, 1, 0, 2'd0, 0, 0, 0);
        check_eq("rst_stall_pc", o_imem_addr, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0),
                 2'($urandom_range(0, 3)),
                 $urandom & ~32'd3, $urandom & ~32'd3, $urandom & ~32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
